// File: rtl/itu656_decoder_if.sv
// itu656_decoder_if
// Bundles the BT.656 receive byte stream and everything the decoder reports
// about it.
//   data         BT.656 byte, one per clock (source -> decoder)
//   pixel_data   stream delayed by four clocks; meaningful while pixel_valid
//   pixel_valid  marks active-video bytes on pixel_data
//   field/vblank/hblank  F/V/H bits of the last accepted timing code
//   line_start   one-clock pulse per accepted SAV
//   frame_start  one-clock pulse on the first SAV of a new frame
//   column       index of the active byte currently on pixel_data
//   line         lines counted since the last frame_start
//   locked       decoder is synchronised to the stream
//   prot_err     one-clock pulse on an XY byte with bad protection bits
// master = stream source / consumer side, slave = decoder side.
interface itu656_decoder_if #(
  parameter int DATA_W = 8,
  parameter int COL_W  = 11,
  parameter int LINE_W = 10
);
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_valid;
  logic              field;
  logic              vblank;
  logic              hblank;
  logic              line_start;
  logic              frame_start;
  logic [COL_W-1:0]  column;
  logic [LINE_W-1:0] line;
  logic              locked;
  logic              prot_err;

  modport master (
    output data,
    input  pixel_data, pixel_valid, field, vblank, hblank,
    input  line_start, frame_start, column, line, locked, prot_err
  );

  modport slave (
    input  data,
    output pixel_data, pixel_valid, field, vblank, hblank,
    output line_start, frame_start, column, line, locked, prot_err
  );
endinterface

// File: rtl/itu656_decoder.sv
// itu656_decoder
// Receive side of the BT.656 link. Hunts for FF 00 00 XY timing codes,
// validates the XY protection bits, tracks field/vblank/hblank and passes the
// active-video bytes out through a four-stage delay line with a valid strobe.
// Ports:
//   clk    27 MHz clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    itu656_decoder_if slave: data in, pixel/status outputs
// All outputs are registered.
module itu656_decoder #(
  parameter int DATA_W  = 8,
  parameter int COL_W   = 11,
  parameter int LINE_W  = 10,
  parameter int TIMEOUT = 2047
) (
  input  logic            clk,
  input  logic            rst_n,
  itu656_decoder_if.slave bus
);
  localparam int GAP_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] BYTE_FF  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] BYTE_00  = {DATA_W{1'b0}};
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(TIMEOUT);
  localparam logic [COL_W-1:0]  COL_MAX  = {COL_W{1'b1}};
  localparam logic [LINE_W-1:0] LINE_MAX = {LINE_W{1'b1}};

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    GOT_FF  = 2'd1,
    GOT_00A = 2'd2,
    GOT_00B = 2'd3
  } state_t;

  // XY is valid when bit7 is set and bits 3:0 carry the Hamming protection of F/V/H.
  function automatic logic xy_ok_f(input logic [7:0] xy);
    logic       f_v;
    logic       v_v;
    logic       h_v;
    logic [3:0] prot_v;
    f_v    = xy[6];
    v_v    = xy[5];
    h_v    = xy[4];
    prot_v = {v_v ^ h_v, f_v ^ h_v, f_v ^ v_v, f_v ^ v_v ^ h_v};
    return xy[7] & (xy[3:0] == prot_v);
  endfunction

  state_t                  state_r;
  state_t                  state_next_s;
  logic [7:0]              xy_s;
  logic                    is_ff_s;
  logic                    is_00_s;
  logic                    code_valid_s;
  logic                    code_err_s;
  logic                    sav_s;
  logic                    eav_s;
  logic                    frame_start_s;
  logic [3:0][DATA_W-1:0]  dly_r;
  logic [3:0]              flag_r;
  logic                    field_r;
  logic                    vblank_r;
  logic                    hblank_r;
  logic                    line_start_r;
  logic                    frame_start_r;
  logic                    prot_err_r;
  logic                    locked_r;
  logic                    armed_r;
  logic [COL_W-1:0]        column_r;
  logic [LINE_W-1:0]       line_r;
  logic [GAP_W-1:0]        gap_r;

  // For wider streams the XY code sits in the top eight bits.
  assign xy_s    = bus.data[DATA_W-1 -: 8];
  assign is_ff_s = (bus.data == BYTE_FF);
  assign is_00_s = (bus.data == BYTE_00);

  // Preamble state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SEARCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Preamble next state; FF always restarts the preamble so FF FF 00 00 XY is caught.
  always_comb begin
    state_next_s = SEARCH;
    case (state_r)
      SEARCH:  state_next_s = is_ff_s ? GOT_FF : SEARCH;
      GOT_FF:  state_next_s = is_00_s ? GOT_00A : (is_ff_s ? GOT_FF : SEARCH);
      GOT_00A: state_next_s = is_00_s ? GOT_00B : (is_ff_s ? GOT_FF : SEARCH);
      GOT_00B: state_next_s = is_ff_s ? GOT_FF : SEARCH;
      default: state_next_s = SEARCH;
    endcase
  end

  // Code decode: the byte seen in GOT_00B is the XY word.
  always_comb begin
    code_valid_s = 1'b0;
    code_err_s   = 1'b0;
    if (state_r == GOT_00B) begin
      code_valid_s = xy_ok_f(xy_s);
      code_err_s   = ~xy_ok_f(xy_s);
    end else begin
      code_valid_s = 1'b0;
      code_err_s   = 1'b0;
    end
  end

  assign sav_s         = code_valid_s & ~xy_s[4];
  assign eav_s         = code_valid_s & xy_s[4];
  assign frame_start_s = sav_s & ~xy_s[5] & armed_r;

  // Delay line; a valid code wipes the flags of its FF 00 00 bytes and of the XY itself.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dly_r  <= {(4 * DATA_W){1'b0}};
      flag_r <= 4'b0000;
    end else begin
      dly_r <= {dly_r[2:0], bus.data};
      if (code_valid_s) begin
        flag_r <= 4'b0000;
      end else begin
        flag_r <= {flag_r[2:0], ~hblank_r & ~vblank_r};
      end
    end
  end

  // Timing flags and per-code pulses; a frame is armed by a V=1,F=0 code.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      field_r       <= 1'b0;
      vblank_r      <= 1'b1;
      hblank_r      <= 1'b1;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      prot_err_r    <= 1'b0;
      armed_r       <= 1'b0;
    end else begin
      line_start_r  <= sav_s;
      frame_start_r <= frame_start_s;
      prot_err_r    <= code_err_s;
      if (code_valid_s) begin
        field_r  <= xy_s[6];
        vblank_r <= xy_s[5];
        hblank_r <= xy_s[4];
      end
      if (code_valid_s && xy_s[5] && !xy_s[6]) begin
        armed_r <= 1'b1;
      end else if (frame_start_s) begin
        armed_r <= 1'b0;
      end
    end
  end

  // Column and line counters, both saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      column_r <= {COL_W{1'b0}};
      line_r   <= {LINE_W{1'b0}};
    end else begin
      if (sav_s) begin
        column_r <= {COL_W{1'b0}};
      end else if (flag_r[3] && (column_r != COL_MAX)) begin
        column_r <= column_r + COL_W'(1'b1);
      end
      if (frame_start_s) begin
        line_r <= {LINE_W{1'b0}};
      end else if (eav_s && (line_r != LINE_MAX)) begin
        line_r <= line_r + LINE_W'(1'b1);
      end
    end
  end

  // Lock tracking; the gap counter saturates at TIMEOUT so lock stays down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_r    <= {GAP_W{1'b0}};
      locked_r <= 1'b0;
    end else begin
      if (code_valid_s) begin
        gap_r    <= {GAP_W{1'b0}};
        locked_r <= 1'b1;
      end else begin
        if (gap_r != GAP_MAX) begin
          gap_r <= gap_r + GAP_W'(1'b1);
        end
        if (code_err_s || (gap_r >= GAP_LAST)) begin
          locked_r <= 1'b0;
        end
      end
    end
  end

  assign bus.pixel_data  = dly_r[3];
  assign bus.pixel_valid = flag_r[3];
  assign bus.field       = field_r;
  assign bus.vblank      = vblank_r;
  assign bus.hblank      = hblank_r;
  assign bus.line_start  = line_start_r;
  assign bus.frame_start = frame_start_r;
  assign bus.column      = column_r;
  assign bus.line        = line_r;
  assign bus.locked      = locked_r;
  assign bus.prot_err    = prot_err_r;
endmodule

// File: tb/tb_itu656_decoder.sv
module tb_itu656_decoder;
  localparam int TIMEOUT = 2047;

  typedef struct {
    int r; int d; int pv; int pd; int col; int ls; int fs;
    int pe; int lk; int f; int v; int h; int line;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  itu656_decoder_if #(.DATA_W(8), .COL_W(11), .LINE_W(10)) bus ();

  itu656_decoder #(.DATA_W(8), .COL_W(11), .LINE_W(10), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  logic [7:0] xy_tab [8];

  // Reference model: byte history, a 4-deep (byte, flag) queue and plain counters.
  logic [7:0] m_hist[$];
  logic [7:0] m_pd[$];
  int         m_pf[$];
  int m_f, m_v, m_h, m_ls, m_fs, m_pe, m_lk, m_armed, m_col, m_line, m_gap;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int xy_index(input logic [7:0] b);
    int idx = -1;
    for (int i = 0; i < 8; i++) if (xy_tab[i] == b) idx = i;
    return idx;
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] b);
    int code, ok, bad, old_pv, bf, bv, bh;
    if (!r) begin
      m_hist.delete(); m_pd.delete(); m_pf.delete();
      for (int i = 0; i < 4; i++) begin m_pd.push_back(8'h00); m_pf.push_back(0); end
      m_f = 0; m_v = 1; m_h = 1; m_ls = 0; m_fs = 0; m_pe = 0; m_lk = 0;
      m_armed = 0; m_col = 0; m_line = 0; m_gap = 0;
    end else begin
      old_pv = m_pf[0];
      code = (m_hist.size() == 3 && m_hist[0] == 8'hFF && m_hist[1] == 8'h00 &&
              m_hist[2] == 8'h00) ? 1 : 0;
      ok  = (code == 1 && xy_index(b) >= 0) ? 1 : 0;
      bad = (code == 1 && ok == 0) ? 1 : 0;
      bf = int'(b[6]); bv = int'(b[5]); bh = int'(b[4]);
      m_hist.push_back(b);
      if (m_hist.size() > 3) void'(m_hist.pop_front());
      m_pd.push_back(b);
      m_pf.push_back((m_h == 0 && m_v == 0) ? 1 : 0);
      void'(m_pd.pop_front());
      void'(m_pf.pop_front());
      if (ok == 1) for (int i = 0; i < 4; i++) m_pf[i] = 0;
      m_ls = (ok == 1 && bh == 0) ? 1 : 0;
      m_fs = (m_ls == 1 && bv == 0 && m_armed == 1) ? 1 : 0;
      if (ok == 1 && bv == 1 && bf == 0) m_armed = 1;
      else if (m_fs == 1) m_armed = 0;
      m_pe = bad;
      if (m_ls == 1) m_col = 0;
      else if (old_pv == 1 && m_col < 2047) m_col++;
      if (m_fs == 1) m_line = 0;
      else if (ok == 1 && bh == 1 && m_line < 1023) m_line++;
      if (ok == 1) begin m_f = bf; m_v = bv; m_h = bh; end
      if (ok == 1) begin
        m_lk = 1; m_gap = 0;
      end else begin
        if (m_gap < TIMEOUT) m_gap++;
        if (bad == 1 || m_gap == TIMEOUT) m_lk = 0;
      end
    end
  endtask

  task automatic compare_model();
    cmp("pixel_valid", int'(bus.pixel_valid), m_pf[0]);
    if (m_pf[0] == 1) cmp("pixel_data", int'(bus.pixel_data), int'(m_pd[0]));
    cmp("column", int'(bus.column), m_col);
    cmp("line", int'(bus.line), m_line);
    cmp("field", int'(bus.field), m_f);
    cmp("vblank", int'(bus.vblank), m_v);
    cmp("hblank", int'(bus.hblank), m_h);
    cmp("line_start", int'(bus.line_start), m_ls);
    cmp("frame_start", int'(bus.frame_start), m_fs);
    cmp("prot_err", int'(bus.prot_err), m_pe);
    cmp("locked", int'(bus.locked), m_lk);
  endtask

  // Called at a falling edge: drive, clock, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [7:0] b);
    rst_n = r;
    bus.data = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic send_code(input logic [7:0] xy);
    step(1'b1, 8'hFF); step(1'b1, 8'h00); step(1'b1, 8'h00); step(1'b1, xy);
  endtask

  task automatic row(input int r, d, pv, pd, col, ls, fs, pe, lk, f, v, h, line);
    vec_t e;
    e = '{r, d, pv, pd, col, ls, fs, pe, lk, f, v, h, line};
    vecs.push_back(e);
  endtask

  initial begin
    xy_tab[0] = 8'h80; xy_tab[1] = 8'h9D; xy_tab[2] = 8'hAB; xy_tab[3] = 8'hB6;
    xy_tab[4] = 8'hC7; xy_tab[5] = 8'hDA; xy_tab[6] = 8'hEC; xy_tab[7] = 8'hF1;
    bus.data = 8'h00;

    //   r  d     pv pd    col ls fs pe lk f  v  h  line
    row(0, 'h00, 0, 'h00, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    row(0, 'h00, 0, 'h00, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    row(0, 'hFF, 0, 'h00, 0,  0, 0, 0, 0, 0, 1, 1, 0);   // reset during FF 00
    row(0, 'h00, 0, 'h00, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    row(1, 'h00, 0, 'h00, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    row(1, 'h9D, 0, 'h00, 0,  0, 0, 0, 0, 0, 1, 1, 0);   // no code after reset
    row(1, 'hFF, 0, 'h00, 0,  0, 0, 0, 0, 0, 1, 1, 0);   // SAV 80
    row(1, 'h00, 0, 'h00, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    row(1, 'h00, 0, 'h9D, 0,  0, 0, 0, 0, 0, 1, 1, 0);
    row(1, 'h80, 0, 'hFF, 0,  1, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h10, 0, 'h00, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h20, 0, 'h00, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h30, 0, 'h80, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h40, 1, 'h10, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h50, 1, 'h20, 1,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h60, 1, 'h30, 2,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h70, 1, 'h40, 3,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h80, 1, 'h50, 4,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h90, 1, 'h60, 5,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'hA0, 1, 'h70, 6,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'hFF, 1, 'h80, 7,  0, 0, 0, 1, 0, 0, 0, 0);   // EAV 9D
    row(1, 'h00, 1, 'h90, 8,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h00, 1, 'hA0, 9,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h9D, 0, 'hFF, 10, 0, 0, 0, 1, 0, 0, 1, 1);
    row(1, 'hFF, 0, 'h00, 10, 0, 0, 0, 1, 0, 0, 1, 1);   // bad XY 81
    row(1, 'h00, 0, 'h00, 10, 0, 0, 0, 1, 0, 0, 1, 1);
    row(1, 'h00, 0, 'h9D, 10, 0, 0, 0, 1, 0, 0, 1, 1);
    row(1, 'h81, 0, 'hFF, 10, 0, 0, 1, 0, 0, 0, 1, 1);
    row(1, 'hFF, 0, 'h00, 10, 0, 0, 0, 0, 0, 0, 1, 1);   // B6 then SAV 80
    row(1, 'h00, 0, 'h00, 10, 0, 0, 0, 0, 0, 0, 1, 1);
    row(1, 'h00, 0, 'h81, 10, 0, 0, 0, 0, 0, 0, 1, 1);
    row(1, 'hB6, 0, 'hFF, 10, 0, 0, 0, 1, 0, 1, 1, 2);
    row(1, 'hFF, 0, 'h00, 10, 0, 0, 0, 1, 0, 1, 1, 2);
    row(1, 'h00, 0, 'h00, 10, 0, 0, 0, 1, 0, 1, 1, 2);
    row(1, 'h00, 0, 'hB6, 10, 0, 0, 0, 1, 0, 1, 1, 2);
    row(1, 'h80, 0, 'hFF, 0,  1, 1, 0, 1, 0, 0, 0, 0);
    row(1, 'hFF, 0, 'h00, 0,  0, 0, 0, 1, 0, 0, 0, 0);   // FF FF 00 00 C7
    row(1, 'hFF, 0, 'h00, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h00, 0, 'h80, 0,  0, 0, 0, 1, 0, 0, 0, 0);
    row(1, 'h00, 1, 'hFF, 0,  0, 0, 0, 1, 0, 0, 0, 0);   // lone FF is an active byte
    row(1, 'hC7, 0, 'hFF, 0,  1, 0, 0, 1, 1, 0, 0, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].r[0], vecs[i].d[7:0]);
      cmp($sformatf("v%0d_pv", i), int'(bus.pixel_valid), vecs[i].pv);
      cmp($sformatf("v%0d_pd", i), int'(bus.pixel_data), vecs[i].pd);
      cmp($sformatf("v%0d_col", i), int'(bus.column), vecs[i].col);
      cmp($sformatf("v%0d_ls", i), int'(bus.line_start), vecs[i].ls);
      cmp($sformatf("v%0d_fs", i), int'(bus.frame_start), vecs[i].fs);
      cmp($sformatf("v%0d_pe", i), int'(bus.prot_err), vecs[i].pe);
      cmp($sformatf("v%0d_lk", i), int'(bus.locked), vecs[i].lk);
      cmp($sformatf("v%0d_f", i), int'(bus.field), vecs[i].f);
      cmp($sformatf("v%0d_v", i), int'(bus.vblank), vecs[i].v);
      cmp($sformatf("v%0d_h", i), int'(bus.hblank), vecs[i].h);
      cmp($sformatf("v%0d_line", i), int'(bus.line), vecs[i].line);
    end

    // Lock timeout: last valid code was C7 above.
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(1'b1, 8'h10);
      if (i == TIMEOUT - 1) cmp("lock_hold_2046", int'(bus.locked), 1);
      if (i == TIMEOUT) cmp("lock_drop_2047", int'(bus.locked), 0);
    end
    send_code(8'h80);
    cmp("relock", int'(bus.locked), 1);

    // Column saturation on an over-long line.
    for (int i = 0; i < 2100; i++) step(1'b1, 8'h55);
    cmp("column_sat", int'(bus.column), 2047);

    // Line saturation over many EAVs.
    for (int i = 0; i < 1030; i++) send_code(8'h9D);
    cmp("line_sat", int'(bus.line), 1023);

    // Randomised traffic against the model.
    for (int s = 0; s < 1500; s++) begin
      int kind, n, f;
      kind = int'($urandom_range(0, 6));
      case (kind)
        0: begin
          n = int'($urandom_range(1, 8));
          for (int k = 0; k < n; k++) step(1'b1, 8'($urandom_range(0, 255)));
        end
        1: send_code(xy_tab[$urandom_range(0, 7)]);
        2: begin
          f = int'($urandom_range(0, 1));
          send_code(xy_tab[f * 4]);
          n = int'($urandom_range(1, 40));
          for (int k = 0; k < n; k++) step(1'b1, 8'($urandom_range(1, 254)));
          send_code(xy_tab[f * 4 + 1]);
        end
        3: send_code(8'($urandom_range(0, 255)));
        4: begin
          step(1'b1, 8'hFF);
          send_code(xy_tab[$urandom_range(0, 7)]);
        end
        5: begin
          if ($urandom_range(0, 19) == 0) step(1'b0, 8'($urandom_range(0, 255)));
          else step(1'b1, 8'hFF);
        end
        default: step(1'b1, 8'h00);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/itu656_decoder.md
Name: itu656_decoder

Overview:
- Receive end of the 8-bit ITU-R BT.656 byte stream at 27 MHz. It is the counterpart of the transmit path, where clipped pixel data and EAV/SAV codes are driven to the video encoder.
- Finds timing reference codes (FF 00 00 XY), checks the XY protection bits, and tracks field, vertical blank and horizontal blank.
- Outputs the active-video bytes with a valid strobe, plus column/line counters and status, for the loopback and capture logic.

Parameters:
- DATA_W, 8, byte width of the stream.
- COL_W, 11, column counter width (active bytes per line, up to 1440).
- LINE_W, 10, line counter width.
- TIMEOUT, 2047, cycles with no valid code before Locked drops.

Ports:
- Clock  in  1  27 MHz system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset.
- Data  in  DATA_W  BT.656 byte; one byte every cycle.
- PixelData  out  DATA_W  delayed Data; meaningful only while PixelValid is high.
- PixelValid  out  1  high for each active-video byte.
- Field  out  1  F bit of the last valid code.
- VBlank  out  1  V bit of the last valid code.
- HBlank  out  1  H bit of the last valid code.
- LineStart  out  1  1-cycle pulse on each valid SAV.
- FrameStart  out  1  1-cycle pulse on the first SAV with V=0 after a code with V=1, F=0.
- Column  out  COL_W  index of the current active byte.
- Line  out  LINE_W  lines since FrameStart.
- Locked  out  1  decoder has synchronised to the stream.
- ProtErr  out  1  1-cycle pulse on an XY byte that fails its check.

Behaviour:
- Reset (Reset==0 at a clock edge):
  - All outputs go to 0, except VBlank=1 and HBlank=1.
  - The FSM goes to SEARCH and the delay line is cleared (all pixel flags 0).
  - Reset takes priority over every other event, including mid-sequence.
- Preamble FSM (states SEARCH, GOT_FF, GOT_00A, GOT_00B):
  - SEARCH: Data==FF goes to GOT_FF.
  - GOT_FF: 00 goes to GOT_00A; FF stays in GOT_FF; anything else goes to SEARCH.
  - GOT_00A: 00 goes to GOT_00B; FF goes to GOT_FF; anything else goes to SEARCH.
  - GOT_00B: the current byte is XY. Always leave to SEARCH, or to GOT_FF if XY==FF.
- XY check:
  - bit7 must be 1. F=bit6, V=bit5, H=bit4.
  - Required protection bits: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H (bits 3:0).
  - Pass: latch F/V/H into Field/VBlank/HBlank.
  - Fail: pulse ProtErr, leave all flags unchanged, clear Locked.
- Delay line:
  - Data passes through a 4-stage shift register, so latency is 4 cycles from Data to PixelData.
  - Each stage carries a pixel flag. A byte's flag is set on entry when HBlank==0 and VBlank==0, using the flags as they stand at that cycle.
  - On a valid code, the flags of the three older stages (the FF 00 00 bytes) are cleared. The XY byte itself enters with flag 0.
  - PixelValid is the flag of stage 4.
- Counters and pulses:
  - Column resets to 0 on each valid SAV (H=0) and increments on every cycle PixelValid is high. It saturates at all-ones and never wraps.
  - Line increments on each valid EAV (H=1), saturates at all-ones, and resets to 0 on FrameStart.
  - LineStart and FrameStart are asserted in the cycle after the XY byte is sampled; both pulses are aligned to that cycle.
- Locked:
  - Set on a valid code.
  - Cleared on ProtErr, or when TIMEOUT consecutive cycles pass with no valid code. A free-running gap counter is reset by each valid code.
- Codes inside active video:
  - Any byte pattern that forms a valid code is honoured, even inside active video.
  - FF inside active video is illegal upstream (the transmit side clips it), so the decoder does not filter it.
- Back-to-back codes: a sequence like FF FF 00 00 XY must be detected.

Test Plan:
- Reset mid-sequence:
  - Stimulus: hold Reset low during FF 00, release, then feed 00 9D.
  - Required: no code detected, Locked=0, VBlank=1, HBlank=1.
- SAV in active video, then EAV:
  - Stimulus: FF 00 00 80 (F=0 V=0 H=0), then bytes 10,20,...,A0 (10 bytes), then FF 00 00 9D.
  - Required: PixelValid high exactly 10 cycles, starting 4 cycles after byte 10 enters, with PixelData 10..A0 and Column 0..9.
  - Required: LineStart pulses once; the EAV bytes are not flagged; Line increments by 1; HBlank=1.
- Protection error:
  - Stimulus: FF 00 00 81.
  - Required: ProtErr pulses once, Locked=0, Field/VBlank/HBlank unchanged, no PixelValid.
- Frame start:
  - Stimulus: FF 00 00 B6 (V=1, F=0), then FF 00 00 80.
  - Required: FrameStart pulses once, Line=0, VBlank=0, Field=0.
- Timeout:
  - Stimulus: one valid code, then 2047 bytes of 10.
  - Required: Locked drops exactly on the 2047th cycle; a further valid code sets Locked again.
- Overlapping preamble:
  - Stimulus: FF FF 00 00 C7 (F=1 V=0 H=0).
  - Required: detected as a valid SAV, Field=1, LineStart pulses, ProtErr stays low.
